// File: rtl/fir_tap_accumulator.sv
// FIR tap accumulator: sums NTAPS signed products per frame, then rounds, saturates
// and registers one output sample per frame behind a valid/ready output stage.
module fir_tap_accumulator #(
  parameter int unsigned NTAPS      = 16,
  parameter int unsigned PROD_WIDTH = 25,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_tdata,
  input  logic                  prod_tvalid,
  input  logic                  prod_tlast,
  output logic                  prod_tready,
  output logic [OUT_WIDTH-1:0]  y_tdata,
  output logic                  y_tvalid,
  input  logic                  y_tready,
  output logic                  sat_o,
  output logic                  frame_err_o
);

  localparam int unsigned CNT_WIDTH  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned EXT_WIDTH  = $clog2(NTAPS);
  localparam int unsigned ACC_WIDTH  = PROD_WIDTH + EXT_WIDTH;
  localparam int unsigned RND_WIDTH  = ACC_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_TAP  = CNT_WIDTH'(NTAPS - 1);
  localparam logic [RND_WIDTH-1:0] RND_CONST =
    (SHIFT > 0) ? (RND_WIDTH'(1) << (SHIFT - 1)) : '0;

  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0]        y_tdata_q, y_tdata_d;
  logic                        y_tvalid_q, y_tvalid_d;
  logic                        sat_q, sat_d;
  logic                        frame_err_q, frame_err_d;

  logic                        is_last_tap;
  logic                        ends_frame;
  logic                        y_stall;
  logic                        accept;
  logic                        frame_end;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [RND_WIDTH-1:0] rounded;
  logic signed [RND_WIDTH-1:0] shifted;
  logic [RND_WIDTH-OUT_WIDTH:0] head;
  logic                        clamped;
  logic [OUT_WIDTH-1:0]        sat_val;

  // Only a frame-ending product needs the output register, so only it can be held off.
  assign is_last_tap = (cnt_q == LAST_TAP);
  assign ends_frame  = is_last_tap || prod_tlast;
  assign y_stall     = y_tvalid_q && !y_tready;
  assign prod_tready = !(ends_frame && y_stall);
  assign accept      = prod_tvalid && prod_tready;
  assign frame_end   = accept && ends_frame;

  // Full-precision sum, round half up, then clamp when the bits above the output sign disagree.
  always_comb begin
    prod_ext = {{EXT_WIDTH{prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
    acc_next = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
    rounded  = {acc_next[ACC_WIDTH-1], acc_next} + RND_CONST;
    shifted  = rounded >>> SHIFT;
    head     = shifted[RND_WIDTH-1:OUT_WIDTH-1];
    clamped  = !((&head) || !(|head));
    if (!clamped) begin
      sat_val = shifted[OUT_WIDTH-1:0];
    end else if (shifted[RND_WIDTH-1]) begin
      sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  // Next-state for the counter, accumulator and output stage.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    y_tdata_d   = y_tdata_q;
    y_tvalid_d  = y_tvalid_q;
    sat_d       = 1'b0;
    frame_err_d = 1'b0;

    if (accept) begin
      acc_d       = acc_next;
      cnt_d       = ends_frame ? '0 : cnt_q + CNT_WIDTH'(1);
      frame_err_d = (prod_tlast != is_last_tap);
    end

    if (y_tvalid_q && y_tready) begin
      y_tvalid_d = 1'b0;
    end

    if (frame_end) begin
      y_tdata_d  = sat_val;
      y_tvalid_d = 1'b1;
      sat_d      = clamped;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      y_tdata_q   <= '0;
      y_tvalid_q  <= 1'b0;
      sat_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      y_tdata_q   <= y_tdata_d;
      y_tvalid_q  <= y_tvalid_d;
      sat_q       <= sat_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign y_tdata     = y_tdata_q;
  assign y_tvalid    = y_tvalid_q;
  assign sat_o       = sat_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Self-checking bench for fir_tap_accumulator (NTAPS=4, SHIFT=8, OUT_WIDTH=16) using a
// scoreboard of expected output samples popped whenever a new result appears.
module tb_fir_tap_accumulator;

  localparam int unsigned NT = 4;
  localparam int unsigned PW = 25;
  localparam int unsigned OW = 16;
  localparam int unsigned SH = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          ap_rst_n;
  logic [PW-1:0] prod_tdata;
  logic          prod_tvalid;
  logic          prod_tlast;
  logic          prod_tready;
  logic [OW-1:0] y_tdata;
  logic          y_tvalid;
  logic          y_tready;
  logic          sat_o;
  logic          frame_err_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic          prev_valid = 1'b0;
  logic          prev_hs    = 1'b0;
  logic [OW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  fir_tap_accumulator #(.NTAPS(NT), .PROD_WIDTH(PW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
    .ap_clk      (clk),
    .ap_rst_n    (ap_rst_n),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tlast  (prod_tlast),
    .prod_tready (prod_tready),
    .y_tdata     (y_tdata),
    .y_tvalid    (y_tvalid),
    .y_tready    (y_tready),
    .sat_o       (sat_o),
    .frame_err_o (frame_err_o)
  );

  // Reference: exact integer sum, round half up, clamp to the output range.
  function automatic exp_t model(input longint sum);
    longint r;
    longint maxv;
    longint minv;
    exp_t   e;
    maxv = (longint'(1) << (OW - 1)) - 1;
    minv = -(longint'(1) << (OW - 1));
    r    = (sum + (longint'(1) << (SH - 1))) >>> SH;
    if (r > maxv) begin
      e.data = OW'(maxv); e.sat = 1'b1;
    end else if (r < minv) begin
      e.data = OW'(minv); e.sat = 1'b1;
    end else begin
      e.data = OW'(r);    e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic push_expected(input int v[4], input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(v[i]);
    sb.push_back(model(s));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Negedge sample: output-stream checks run every cycle.
  task automatic sample();
    logic new_res;
    exp_t e;
    @(negedge clk);
    if (!ap_rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      return;
    end
    if (prev_valid && !prev_hs) begin
      checks++;
      if (y_tvalid !== 1'b1 || y_tdata !== prev_data) begin
        failures++;
        $display("FAIL hold: valid=%b data=%0h required valid=1 data=%0h", y_tvalid, y_tdata, prev_data);
      end
    end
    new_res = y_tvalid && (!prev_valid || prev_hs);
    checks++;
    if (new_res) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: data=%0h with empty scoreboard", y_tdata);
      end else begin
        e = sb.pop_front();
        if (y_tdata !== e.data || sat_o !== e.sat) begin
          failures++;
          $display("FAIL result: data=%0h sat=%b required data=%0h sat=%b", y_tdata, sat_o, e.data, e.sat);
        end
      end
    end else if (sat_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_spurious: sat_o=%b required 0", sat_o);
    end
    prev_valid = y_tvalid;
    prev_hs    = y_tvalid && y_tready;
    prev_data  = y_tdata;
  endtask

  task automatic send_product(input int val, input logic last);
    bit done = 0;
    prod_tdata  = PW'(val);
    prod_tlast  = last;
    prod_tvalid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      sample();
      if (prod_tready) done = 1;
      advance();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: prod_tready=%b required 1 within 20 cycles", prod_tready);
    end
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
  endtask

  // last_idx >= NT means tlast is never raised and the frame ends on tap count.
  task automatic send_frame(input int v[4], input int last_idx);
    int n;
    n = (last_idx < int'(NT)) ? last_idx + 1 : int'(NT);
    push_expected(v, n);
    for (int i = 0; i < n; i++) send_product(v[i], i == last_idx);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (y_tdata !== '0 || y_tvalid !== 1'b0 || sat_o !== 1'b0 || frame_err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: data=%0h valid=%b sat=%b ferr=%b required all 0",
               tag, y_tdata, y_tvalid, sat_o, frame_err_o);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; prod_tvalid = 1'b0; prod_tlast = 1'b0; prod_tdata = '0; y_tready = 1'b1;
    advance();
    advance();
    sample();
    check_outputs_zero("reset_outputs");
    advance();
    ap_rst_n = 1'b1;
    sample();
    checks++;
    if (prod_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: prod_tready=%b required 1", prod_tready);
    end
    advance();
  endtask

  task automatic test_basic();
    send_frame('{256, 256, 256, 256}, 3);
    sample();
    checks++;
    if (y_tvalid !== 1'b1 || y_tdata !== 16'd4 || sat_o !== 1'b0) begin
      failures++;
      $display("FAIL basic: valid=%b data=%0d sat=%b required valid=1 data=4 sat=0", y_tvalid, y_tdata, sat_o);
    end
    advance();
    sample();
    checks++;
    if (y_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL basic_clear: y_tvalid=%b required 0", y_tvalid);
    end
    advance();
  endtask

  task automatic test_rounding();
    send_frame('{128, 0, 0, 0}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'd1) begin
      failures++;
      $display("FAIL round_pos: data=%0d required 1", y_tdata);
    end
    advance();
    send_frame('{-128, 0, 0, 0}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'd0) begin
      failures++;
      $display("FAIL round_neg: data=%0d required 0", y_tdata);
    end
    advance();
  endtask

  task automatic test_saturation();
    send_frame('{16777215, 16777215, 16777215, 16777215}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'h7fff || sat_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos: data=%0h sat=%b required 7fff sat=1", y_tdata, sat_o);
    end
    advance();
    send_frame('{-16777216, -16777216, -16777216, -16777216}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'h8000 || sat_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: data=%0h sat=%b required 8000 sat=1", y_tdata, sat_o);
    end
    advance();
  endtask

  task automatic test_frame_err();
    send_frame('{512, 512, 0, 0}, 1);
    sample();
    checks++;
    if (frame_err_o !== 1'b1 || y_tdata !== 16'd4) begin
      failures++;
      $display("FAIL early_tlast: ferr=%b data=%0d required ferr=1 data=4", frame_err_o, y_tdata);
    end
    advance();
    sample();
    checks++;
    if (frame_err_o !== 1'b0) begin
      failures++;
      $display("FAIL ferr_pulse: frame_err_o=%b required 0", frame_err_o);
    end
    advance();
    send_frame('{256, 256, 256, 256}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'd4 || frame_err_o !== 1'b0) begin
      failures++;
      $display("FAIL after_err: data=%0d ferr=%b required data=4 ferr=0", y_tdata, frame_err_o);
    end
    advance();
    send_frame('{100, 200, 300, 400}, 4);
    sample();
    checks++;
    if (frame_err_o !== 1'b1 || y_tdata !== 16'd4) begin
      failures++;
      $display("FAIL missing_tlast: ferr=%b data=%0d required ferr=1 data=4", frame_err_o, y_tdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    y_tready = 1'b0;
    send_frame('{256, 256, 256, 256}, 3);
    push_expected('{512, 512, 512, 512}, 4);
    for (int i = 0; i < 3; i++) send_product(512, 1'b0);
    prod_tdata = PW'(512); prod_tlast = 1'b1; prod_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (prod_tready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready: prod_tready=%b required 0", prod_tready);
      end
      advance();
    end
    y_tready = 1'b1;
    sample();
    checks++;
    if (prod_tready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: prod_tready=%b required 1", prod_tready);
    end
    advance();
    prod_tvalid = 1'b0; prod_tlast = 1'b0;
    sample();
    checks++;
    if (y_tvalid !== 1'b1 || y_tdata !== 16'd8) begin
      failures++;
      $display("FAIL b2b_result: valid=%b data=%0d required valid=1 data=8", y_tvalid, y_tdata);
    end
    advance();
    sample();
    advance();
  endtask

  task automatic test_reset_midframe();
    y_tready = 1'b0;
    send_frame('{256, 256, 256, 256}, 3);
    send_product(256, 1'b0);
    send_product(256, 1'b0);
    ap_rst_n = 1'b0;
    sample();
    advance();
    sample();
    check_outputs_zero("midframe_reset");
    y_tready = 1'b1;
    advance();
    ap_rst_n = 1'b1;
    send_frame('{256, 256, 256, 256}, 3);
    sample();
    checks++;
    if (y_tdata !== 16'd4 || y_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL no_residue: data=%0d valid=%b required data=4 valid=1", y_tdata, y_tvalid);
    end
    advance();
  endtask

  task automatic test_random();
    int v[4];
    int n;
    int li;
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 2097151)) - 1048576;
      li = (n < 4) ? n - 1 : int'($urandom_range(3, 4));
      send_frame(v, li);
    end
    for (int i = 0; i < 4; i++) begin
      sample();
      advance();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_accumulator.md
FIR_TAP_ACCUMULATOR -- requirements
Module: fir_tap_accumulator

Interface
REQ-001 The block SHALL have parameter NTAPS, default 16, meaning products summed per output sample (2..256).
REQ-002 The block SHALL have parameter PROD_WIDTH, default 25, meaning the signed product width (16s x 9s multiplier output).
REQ-003 The block SHALL have parameter OUT_WIDTH, default 16, meaning the signed output sample width.
REQ-004 The block SHALL have parameter SHIFT, default 8, meaning the fractional bits removed (Q1.8 coefficients).
REQ-005 The block SHALL derive localparam ACC_WIDTH = PROD_WIDTH + clog2(NTAPS), the full-precision accumulator width.
REQ-006 The block SHALL have port ap_clk  input  1  the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port ap_rst_n  input  1  reset, synchronous and active-low.
REQ-008 The block SHALL have port prod_tdata  input  PROD_WIDTH  signed product from the multiplier.
REQ-009 The block SHALL have port prod_tvalid  input  1  product valid.
REQ-010 The block SHALL have port prod_tlast  input  1  marks the last product of a sample frame.
REQ-011 The block SHALL have port prod_tready  output  1  product accepted when prod_tvalid && prod_tready.
REQ-012 The block SHALL have port y_tdata  output  OUT_WIDTH  rounded, saturated signed output sample.
REQ-013 The block SHALL have port y_tvalid  output  1  output valid.
REQ-014 The block SHALL have port y_tready  input  1  downstream ready.
REQ-015 The block SHALL have port sat_o  output  1  one-cycle pulse when a result is saturated.
REQ-016 The block SHALL have port frame_err_o  output  1  one-cycle pulse on prod_tlast/tap-count mismatch.

Function
REQ-017 The block SHALL keep a tap counter cnt (0..NTAPS-1) and an ACC_WIDTH signed accumulator acc.
REQ-018 On an accepted product with cnt==0, acc SHALL load sign-extended prod_tdata, not add to the old value.
REQ-019 On an accepted product with cnt!=0, acc SHALL become acc + sign-extended prod_tdata, with no intermediate overflow.
REQ-020 A frame SHALL end on an accepted product where cnt==NTAPS-1 or prod_tlast==1, whichever comes first; cnt then returns to 0.
REQ-021 frame_err_o SHALL pulse the cycle after acceptance when prod_tlast disagrees with (cnt==NTAPS-1); the frame still ends and its result is still emitted.
REQ-022 At frame end, final = acc_next + 2^(SHIFT-1), arithmetically shifted right by SHIFT (round half up), SHALL be saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-023 The saturated result SHALL be registered into y_tdata with y_tvalid=1 on the cycle after the final product is accepted (latency 1).
REQ-024 sat_o SHALL pulse in the same cycle y_tvalid rises for a clamped result.
REQ-025 y_tdata/y_tvalid SHALL hold stable while y_tvalid && !y_tready; y_tvalid SHALL clear after a handshake with no new result loading.
REQ-026 prod_tready SHALL be 0 only when the next product would end a frame (cnt==NTAPS-1 or prod_tlast) and y_tvalid && !y_tready; otherwise 1.
REQ-027 When a y handshake and a frame-ending acceptance coincide, the new result SHALL load and y_tvalid SHALL stay 1.
REQ-028 Non-final products SHALL be accepted while the output is stalled (one frame of overlap).

Reset
REQ-029 While ap_rst_n==0 at a clock edge: cnt=0, acc=0, y_tdata=0, y_tvalid=0, sat_o=0, frame_err_o=0; prod_tready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted mid-frame SHALL discard the partial sum; the next accepted product starts a new frame at cnt=0.

Verification (NTAPS=4, SHIFT=8, OUT_WIDTH=16)
REQ-031 Four products of 256, tlast on 4th, y_tready=1 -> y_tdata=4, y_tvalid one cycle after the 4th acceptance, sat_o=0.
REQ-032 Frame sums 128 and -128 -> outputs 1 and 0 (round half up).
REQ-033 Four products of 16777215 -> 32767 with sat_o pulse; four of -16777216 -> -32768 with sat_o pulse.
REQ-034 y_tready=0 with back-to-back frames -> first three products of frame 2 accepted, prod_tready=0 on the 4th until y_tready=1; frame-2 result appears the cycle after, no data lost.
REQ-035 tlast on 2nd product (values 512, 512) -> frame_err_o pulse, y_tdata=4, next product starts at cnt=0.
REQ-036 ap_rst_n=0 after two products, then a full frame of 256 -> y_tdata=4 (no residue), all outputs 0 during reset.
